// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port unified memory between the fetch (IF) and memory (DM) stages.
// One access in flight at a time; alternates grants under contention and raises stage stalls.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_valid,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_valid,
    output logic                  stall_if,
    output logic                  stall_mem,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e                  state_q;
    logic                    owner_dm_q;
    logic                    store_q;
    logic                    last_dm_q;
    logic [3:0]              cnt_q;
    logic                    mem_en_q;
    logic                    mem_we_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic [DATA_WIDTH-1:0]   if_rdata_q;
    logic [DATA_WIDTH-1:0]   dm_rdata_q;
    logic                    if_valid_q;
    logic                    dm_valid_q;
    logic                    grant_dm;

    // Under contention DM wins unless it took the previous grant.
    assign grant_dm = dm_req & (~if_req | ~last_dm_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            owner_dm_q  <= 1'b0;
            store_q     <= 1'b0;
            last_dm_q   <= 1'b0;
            cnt_q       <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
        end else begin
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (if_req || dm_req) begin
                        owner_dm_q <= grant_dm;
                        last_dm_q  <= grant_dm;
                        store_q    <= grant_dm & dm_we;
                        mem_addr_q <= grant_dm ? dm_addr : if_addr;
                        if (grant_dm) begin
                            mem_wdata_q <= dm_wdata;
                        end
                        mem_en_q <= 1'b1;
                        mem_we_q <= grant_dm & dm_we;
                        state_q  <= StIssue;
                    end
                end
                StIssue: begin
                    cnt_q   <= 4'(MEM_LATENCY);
                    state_q <= StWait;
                end
                StWait: begin
                    cnt_q <= cnt_q - 4'd1;
                    // Last latency cycle: mem_rdata is valid now.
                    if (cnt_q == 4'd1) begin
                        if (owner_dm_q) begin
                            if (!store_q) begin
                                dm_rdata_q <= mem_rdata;
                            end
                            dm_valid_q <= 1'b1;
                        end else begin
                            if_rdata_q <= mem_rdata;
                            if_valid_q <= 1'b1;
                        end
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign stall_if  = if_req & ~if_valid_q;
    assign stall_mem = dm_req & ~dm_valid_q;

endmodule
